// File: rtl/motor_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// motor_ramp_ctrl
//
// APB-programmable speed sequencer for one H-bridge/PWM motor channel.
// Ramps the PWM pulse width toward a commanded target at a programmable
// rate. Before a direction reversal it ramps down to zero and holds the
// bridge in brake for a fixed dead-time.
//
// Register window (offsets from BASE_ADDR, matched on PADDR[15:0]):
//   0x0 TARGET   [16] dir (0 fwd, 1 rev), [15:0] magnitude (clamped to PERIOD_CC)
//   0x4 STEP     [15:0] duty change per tick (0 = jump straight to goal)
//   0x8 TICK_DIV [15:0] clocks per tick (0 behaves as 1)
//   0xC STATUS   [15:0] duty, [16] cur_dir, [18:17] state, [19] at_target (RO)
//
// Ports:
//   PCLK, PRESERN      clock, synchronous active-high reset
//   PSEL..PWDATA       APB slave inputs
//   PRDATA             combinational read data (0 when not reading)
//   PREADY, PSLVERR    tied 1 / 0 (zero-wait, never errors)
//   HBRIDGE_CMD        00 coast, 01 forward, 10 reverse, 11 brake (registered)
//   PW_CC              zero-extended 16-bit duty to the PWM block
//   PWM_EN             PWM enable (registered)
// ---------------------------------------------------------------------------
module motor_ramp_ctrl #(
  parameter logic [15:0] BASE_ADDR        = 16'h0000,
  parameter int unsigned PERIOD_CC        = 5000,
  parameter int unsigned DEFAULT_STEP     = 50,
  parameter int unsigned DEFAULT_TICK_DIV = 1000,
  parameter int unsigned DEADTIME_CC      = 500
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [1:0]  HBRIDGE_CMD,
  output logic [31:0] PW_CC,
  output logic        PWM_EN
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_BRAKE = 2'd3
  } state_t;

  localparam int unsigned DT_W = (DEADTIME_CC > 1) ? $clog2(DEADTIME_CC) : 1;
  localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME_CC - 1);

  localparam logic [1:0] CMD_COAST = 2'b00;
  localparam logic [1:0] CMD_FWD   = 2'b01;
  localparam logic [1:0] CMD_REV   = 2'b10;
  localparam logic [1:0] CMD_BRAKE = 2'b11;

  // Programmable registers
  logic        target_dir;
  logic [15:0] target_mag;
  logic [15:0] step_r;
  logic [15:0] tick_div;

  // Sequencer state
  state_t      state, state_nxt;
  logic [15:0] duty, duty_nxt;
  logic        cur_dir, dir_nxt;
  logic [15:0] tick_cnt, tick_nxt;
  logic [DT_W-1:0] dt_cnt, dt_nxt;
  logic [1:0]  hbridge_q;
  logic        pwm_en_q;

  // -------------------------------------------------------------------------
  // APB decode
  // -------------------------------------------------------------------------
  logic        wr_en;
  logic        sel_target, sel_step, sel_tick, sel_status;
  logic [15:0] wr_mag;

  assign wr_en      = PSEL & PENABLE & PWRITE;
  assign sel_target = (PADDR[15:0] == BASE_ADDR);
  assign sel_step   = (PADDR[15:0] == BASE_ADDR + 16'h0004);
  assign sel_tick   = (PADDR[15:0] == BASE_ADDR + 16'h0008);
  assign sel_status = (PADDR[15:0] == BASE_ADDR + 16'h000C);

  // A magnitude beyond one PWM period is meaningless; store the period instead.
  assign wr_mag = (32'(PWDATA[15:0]) > PERIOD_CC) ? 16'(PERIOD_CC) : PWDATA[15:0];

  // Upper address/data bits are outside the decoded window.
  logic unused_bits;
  assign unused_bits = ^{PADDR[31:16], PWDATA[31:17]};

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (PRESERN) begin
      target_dir <= 1'b0;
      target_mag <= '0;
      step_r     <= 16'(DEFAULT_STEP);
      tick_div   <= 16'(DEFAULT_TICK_DIV);
    end else if (wr_en) begin
      if (sel_target) begin
        target_dir <= PWDATA[16];
        target_mag <= wr_mag;
      end
      if (sel_step) step_r   <= PWDATA[15:0];
      if (sel_tick) tick_div <= PWDATA[15:0];
    end
  end

  logic [31:0] status_word;
  assign status_word = {12'b0, (state == ST_HOLD), state, cur_dir, duty};

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      if (sel_target)      PRDATA = {15'b0, target_dir, target_mag};
      else if (sel_step)   PRDATA = {16'b0, step_r};
      else if (sel_tick)   PRDATA = {16'b0, tick_div};
      else if (sel_status) PRDATA = status_word;
    end
  end

  // -------------------------------------------------------------------------
  // Ramp datapath
  // -------------------------------------------------------------------------
  logic [15:0] goal;
  logic [15:0] tick_last;
  logic        tick;
  logic [16:0] up_sum;
  logic [16:0] dn_gap;
  logic [15:0] duty_stepped;

  // Opposite direction means ramp to zero first; the brake handles the flip.
  assign goal      = (target_dir == cur_dir) ? target_mag : 16'd0;
  assign tick_last = (tick_div == 16'd0) ? 16'd0 : tick_div - 16'd1;
  assign tick      = (tick_cnt == tick_last);

  // 17-bit so neither the step up nor the step down can wrap past the goal.
  assign up_sum = {1'b0, duty} + {1'b0, step_r};
  assign dn_gap = {1'b0, duty} - {1'b0, goal};

  always_comb begin
    duty_stepped = goal;
    if (duty < goal) begin
      if (step_r != 16'd0 && up_sum <= {1'b0, goal}) duty_stepped = up_sum[15:0];
    end else begin
      if (step_r != 16'd0 && {1'b0, step_r} < dn_gap) duty_stepped = duty - step_r;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer next-state
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_nxt = state;
    duty_nxt  = duty;
    dir_nxt   = cur_dir;
    tick_nxt  = '0;
    dt_nxt    = dt_cnt;
    unique case (state)
      ST_IDLE: begin
        if (target_mag != 16'd0) begin
          dir_nxt   = target_dir;
          state_nxt = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (duty == goal) begin
          if (goal != 16'd0)            state_nxt = ST_HOLD;
          else if (target_mag == 16'd0) state_nxt = ST_IDLE;
          else begin
            state_nxt = ST_BRAKE;
            dt_nxt    = '0;
          end
        end else if (tick) begin
          duty_nxt = duty_stepped;
        end else begin
          tick_nxt = tick_cnt + 16'd1;
        end
      end
      ST_HOLD: begin
        if (target_mag != duty || target_dir != cur_dir) state_nxt = ST_RAMP;
      end
      ST_BRAKE: begin
        duty_nxt = '0;
        // The dead-time runs to completion; target changes only pick the exit.
        if (dt_cnt == DT_LAST) begin
          dir_nxt   = target_dir;
          state_nxt = (target_mag != 16'd0) ? ST_RAMP : ST_IDLE;
        end else begin
          dt_nxt = dt_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  function automatic logic [1:0] cmd_for(input state_t s, input logic dir);
    case (s)
      ST_RAMP, ST_HOLD: return dir ? CMD_REV : CMD_FWD;
      ST_BRAKE:         return CMD_BRAKE;
      default:          return CMD_COAST;
    endcase
  endfunction

  // Outputs are derived from next-state so they change on the same edge as
  // the state they describe.
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      state     <= ST_IDLE;
      duty      <= '0;
      cur_dir   <= 1'b0;
      tick_cnt  <= '0;
      dt_cnt    <= '0;
      hbridge_q <= CMD_COAST;
      pwm_en_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      duty      <= duty_nxt;
      cur_dir   <= dir_nxt;
      tick_cnt  <= tick_nxt;
      dt_cnt    <= dt_nxt;
      hbridge_q <= cmd_for(state_nxt, dir_nxt);
      pwm_en_q  <= (state_nxt == ST_RAMP) || (state_nxt == ST_HOLD);
    end
  end

  assign HBRIDGE_CMD = hbridge_q;
  assign PWM_EN      = pwm_en_q;
  assign PW_CC       = {16'b0, duty};

endmodule

// File: doc/motor_ramp_ctrl.md
Name: motor_ramp_ctrl

Overview:
APB-programmable sequencer for one H-bridge/PWM motor channel. It ramps PWM pulse width toward a commanded target speed at a programmable rate. It enforces a brake dead-time before any direction reversal and drives the H-bridge command plus the PWM pulse-width/enable. It sits between the APB bus and the H-bridge and PWM blocks of a motor channel, replacing direct CPU writes to those blocks.

Parameters:
BASE_ADDR, 16'h0000, base of this block's 4-register window (offsets 0x0/0x4/0x8/0xC, compared against PADDR[15:0])
PERIOD_CC, 5000, PWM period in clocks; maximum legal pulse width
DEFAULT_STEP, 50, reset value of STEP register
DEFAULT_TICK_DIV, 1000, reset value of TICK_DIV register
DEADTIME_CC, 500, clocks spent in BRAKE before reversing direction

Ports:
PCLK  in  1  the single clock
PRESERN  in  1  reset; synchronous and active-high
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  APB write
PADDR  in  32  APB address
PWDATA  in  32  APB write data
PRDATA  out  32  APB read data
PREADY  out  1  constant 1
PSLVERR  out  1  constant 0
HBRIDGE_CMD  out  2  00 coast, 01 forward, 10 reverse, 11 brake
PW_CC  out  32  pulse width to PWM, zero-extended 16-bit duty
PWM_EN  out  1  PWM enable

Behaviour:
- Reset (PRESERN=1 at a PCLK edge): TARGET=0, STEP=DEFAULT_STEP, TICK_DIV=DEFAULT_TICK_DIV, state=IDLE, duty=0, cur_dir=0, tick and deadtime counters=0. Outputs: HBRIDGE_CMD=00, PW_CC=0, PWM_EN=0, PRDATA=0.
- Register write: PSEL&PENABLE&PWRITE with an address match; the register updates at that edge.
  - 0x0 TARGET: [16] dir (0 fwd, 1 rev), [15:0] magnitude. A magnitude above PERIOD_CC is stored as PERIOD_CC.
  - 0x4 STEP: [15:0].
  - 0x8 TICK_DIV: [15:0]; value 0 behaves as 1.
  - 0xC STATUS: read-only; writes are ignored.
  - Unmatched addresses are ignored.
- Register read: PRDATA is combinational, equal to the addressed register when PSEL&!PWRITE, else 0.
  - STATUS: [15:0] duty, [16] cur_dir, [18:17] state (0 IDLE, 1 RAMP, 2 HOLD, 3 BRAKE), [19] at_target (state==HOLD), others 0.
- goal = TARGET.mag if TARGET.dir==cur_dir, else 0. goal is re-evaluated every cycle, so a mid-ramp target change redirects the ramp without restart.
- Tick: counter runs 0..TICK_DIV-1 only in RAMP and clears on RAMP entry. Tick pulses when it reaches TICK_DIV-1, so the first duty change comes TICK_DIV cycles after RAMP entry.
- On a tick, duty moves toward goal by STEP, clamped so it never overshoots goal. STEP=0 means duty=goal in one tick. Arithmetic is 17-bit, with no wrap on either the up or down step.
- FSM:
  - IDLE: if TARGET.mag>0, set cur_dir=TARGET.dir and go to RAMP next cycle.
  - RAMP: when duty==goal:
    - goal>0 → HOLD;
    - goal==0 and TARGET.mag==0 → IDLE;
    - goal==0 with a direction mismatch → BRAKE.
  - HOLD: if TARGET.mag!=duty or TARGET.dir!=cur_dir → RAMP.
  - BRAKE: duty=0; count DEADTIME_CC cycles, then cur_dir=TARGET.dir; if TARGET.mag>0 go to RAMP, else IDLE. TARGET writes during BRAKE do not shorten it.
- Outputs are registered and follow state/duty:
  - IDLE: HBRIDGE_CMD=00.
  - RAMP/HOLD: 01 if cur_dir=0, 10 if cur_dir=1; PWM_EN=1.
  - BRAKE: 11, PWM_EN=0.
  - PW_CC={16'b0,duty}.
- Reset asserted mid-operation (any state) returns all state to reset values at that edge. The H-bridge never transitions directly between 01 and 10.

Test Plan:
1. Assert PRESERN for 2 cycles, then read 0x4/0x8/0xC → 50, 1000, 0; HBRIDGE_CMD=00, PW_CC=0, PWM_EN=0.
2. Write STEP=100, TICK_DIV=10, TARGET=0x003E8 (fwd 1000) → HBRIDGE_CMD=01 and PWM_EN=1 within 2 cycles. PW_CC steps 100,200..1000, one step every 10 cycles. Then STATUS[19]=1, STATUS[18:17]=2.
3. From HOLD at fwd 1000, write TARGET=0x101F4 (rev 500) → duty ramps down to 0 in 10 ticks, then HBRIDGE_CMD=11 for exactly 500 cycles. Then 10, duty ramps to 500 (5 ticks); 01→10 never occurs directly.
4. Write TARGET magnitude 6000 → TARGET reads back 5000. With STEP=0 and TICK_DIV=0, duty reaches 5000 one cycle after RAMP entry.
5. From HOLD at 1000, write STEP=300 and TARGET=0 → duty goes 700, 400, 100, 0, then IDLE: HBRIDGE_CMD=00, PWM_EN=0.
6. Assert PRESERN for one cycle mid-BRAKE → next cycle HBRIDGE_CMD=00, PW_CC=0, STATUS=0, TARGET=0. Writes to 0xC and unmapped 0x10 change nothing.
